// File: rtl/ccg_sweep_ctrl_if.sv
// ccg_sweep_ctrl_if: response beat stream (vector index + captured CUT response) with valid/ready
interface ccg_sweep_ctrl_if #(parameter int N_IN = 7, parameter int N_OUT = 7);
  logic out_valid;
  logic out_ready;
  logic [N_IN-1:0] out_vec;
  logic [N_OUT-1:0] out_resp;
  modport master(output out_valid, out_vec, out_resp, input out_ready);
  modport slave(input out_valid, out_vec, out_resp, output out_ready);
endinterface

// File: rtl/ccg_sweep_ctrl.sv
// ccg_sweep_ctrl: drives every input vector onto a combinational CUT, streams responses, folds them into a MISR
module ccg_sweep_ctrl #(
  parameter int N_IN = 7,
  parameter int N_OUT = 7,
  parameter int SETTLE = 1,
  parameter logic [15:0] MISR_POLY = 16'h1021,
  parameter logic [15:0] MISR_SEED = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic [N_IN-1:0] cut_x,
  input  logic [N_OUT-1:0] cut_f,
  ccg_sweep_ctrl_if.master beat,
  output logic [15:0] signature
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_PRESENT, S_DONE} state_t;
  state_t state, state_nxt;
  logic [N_IN-1:0] vec;
  logic [CW-1:0] cnt;
  logic go, cap, hs, last;
  logic [15:0] sig_nxt;
  assign go = start && !abort && (state == S_IDLE || state == S_DONE);
  assign cap = !abort && state == S_SETTLE && cnt == '0;
  assign hs = !abort && state == S_PRESENT && beat.out_ready;
  assign last = &vec;
  assign sig_nxt = {signature[14:0], 1'b0} ^ (signature[15] ? MISR_POLY : 16'h0) ^ 16'(beat.out_resp);
  assign busy = state == S_SETTLE || state == S_PRESENT;
  assign done = state == S_DONE;
  assign beat.out_valid = state == S_PRESENT;
  // vec stays at the last vector in DONE, so the CUT keeps seeing it
  assign cut_x = vec;
  always_comb begin
    state_nxt = state;
    state_nxt = abort ? S_IDLE : go ? S_SETTLE : cap ? S_PRESENT : hs ? (last ? S_DONE : S_SETTLE) : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
      cnt <= '0;
      beat.out_vec <= '0;
      beat.out_resp <= '0;
      signature <= MISR_SEED;
    end else begin
      if (go) begin
        vec <= '0;
        cnt <= CW'(SETTLE - 1);
        signature <= MISR_SEED;
      end
      if (!abort && state == S_SETTLE && cnt != '0) cnt <= cnt - CW'(1);
      if (cap) begin
        beat.out_vec <= vec;
        beat.out_resp <= cut_f;
      end
      if (hs) begin
        signature <= sig_nxt;
        if (!last) begin
          vec <= vec + N_IN'(1);
          cnt <= CW'(SETTLE - 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// tb_ccg_sweep_ctrl: table-driven sweeps with random backpressure against a behavioural MISR model
module tb_ccg_sweep_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v, abort_v, ready_v, busy_v, done_v, valid_v;
  logic [6:0] x_v[2], f_v[2], vec_v[2], resp_v[2];
  logic [15:0] sig_v[2];
  int mode_v[2];
  logic [6:0] cut_lut[128];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] cutf(input int mode, input logic [6:0] x);
    return mode == 0 ? 7'h0 : mode == 1 ? x : cut_lut[x];
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [6:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {9'h0, r};
  endfunction

  function automatic logic [15:0] golden(input int mode);
    logic [15:0] s = 16'hFFFF;
    for (int v = 0; v < 128; v++) s = misr(s, cutf(mode, 7'(v)));
    return s;
  endfunction

  ccg_sweep_ctrl_if #(.N_IN(7), .N_OUT(7)) b0();
  ccg_sweep_ctrl_if #(.N_IN(7), .N_OUT(7)) b1();

  assign f_v[0] = cutf(mode_v[0], x_v[0]);
  assign f_v[1] = cutf(mode_v[1], x_v[1]);
  assign b0.out_ready = ready_v[0];
  assign b1.out_ready = ready_v[1];
  assign valid_v = {b1.out_valid, b0.out_valid};
  assign vec_v[0] = b0.out_vec;
  assign vec_v[1] = b1.out_vec;
  assign resp_v[0] = b0.out_resp;
  assign resp_v[1] = b1.out_resp;

  ccg_sweep_ctrl #(.N_IN(7), .N_OUT(7), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .cut_x(x_v[0]), .cut_f(f_v[0]), .beat(b0.master), .signature(sig_v[0]));

  ccg_sweep_ctrl #(.N_IN(7), .N_OUT(7), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .cut_x(x_v[1]), .cut_f(f_v[1]), .beat(b1.master), .signature(sig_v[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic sweep(input int d, input int mode, input int rpct, output int cyc, output logic [15:0] sig);
    int ev = 0;
    logic held = 1'b0;
    logic [6:0] hv = '0, hr = '0;
    logic [15:0] m = 16'hFFFF;
    mode_v[d] = mode;
    @(negedge clk);
    start_v[d] = 1'b1;
    ready_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    cyc = 0;
    while (!done_v[d] && cyc < 2000) begin
      chk("sig_track", 32'(sig_v[d]), 32'(m));
      if (held) begin
        chk("stall_valid", 32'(valid_v[d]), 32'd1);
        chk("stall_vec", 32'(vec_v[d]), 32'(hv));
        chk("stall_resp", 32'(resp_v[d]), 32'(hr));
        chk("stall_x", 32'(x_v[d]), 32'(hv));
      end
      start_v[d] = cyc == 37;
      ready_v[d] = $urandom_range(99) < 32'(rpct);
      held = 1'b0;
      if (valid_v[d] && ready_v[d]) begin
        chk("beat_vec", 32'(vec_v[d]), 32'(ev));
        chk("beat_resp", 32'(resp_v[d]), 32'(cutf(mode, 7'(ev))));
        chk("beat_x", 32'(x_v[d]), 32'(ev));
        m = misr(m, cutf(mode, 7'(ev)));
        ev++;
      end else if (valid_v[d]) begin
        held = 1'b1;
        hv = vec_v[d];
        hr = resp_v[d];
      end
      @(negedge clk);
      cyc++;
    end
    start_v[d] = 1'b0;
    ready_v[d] = 1'b1;
    chk("beat_count", 32'(ev), 32'd128);
    chk("done_level", 32'(done_v[d]), 32'd1);
    chk("busy_after", 32'(busy_v[d]), 32'd0);
    chk("x_hold_last", 32'(x_v[d]), 32'd127);
    chk("sig_model", 32'(sig_v[d]), 32'(m));
    sig = sig_v[d];
  endtask

  typedef struct {
    int dut;
    int mode;
    int rpct;
    logic [15:0] exp_sig;
    int exp_cyc;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int cyc, n;
    logic [15:0] s, sig;
    logic [6:0] r;
    rst = 1'b1;
    start_v = '0;
    abort_v = '0;
    ready_v = '1;
    mode_v[0] = 0;
    mode_v[1] = 0;
    for (int i = 0; i < 128; i++) cut_lut[i] = 7'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_x", 32'(x_v[0]), 32'd0);
    chk("rst_valid", 32'(valid_v[0]), 32'd0);
    chk("rst_vec", 32'(vec_v[0]), 32'd0);
    chk("rst_resp", 32'(resp_v[0]), 32'd0);
    chk("rst_sig", 32'(sig_v[0]), 32'hFFFF);
    chk("rst_sig1", 32'(sig_v[1]), 32'hFFFF);

    tbl[0] = '{0, 0, 100, golden(0), 256};
    tbl[1] = '{0, 1, 100, golden(1), 256};
    tbl[2] = '{0, 2, 100, golden(2), 256};
    tbl[3] = '{0, 2, 60, golden(2), -1};
    tbl[4] = '{1, 1, 100, golden(1), 512};
    tbl[5] = '{1, 2, 70, golden(2), -1};
    for (int i = 0; i < 6; i++) begin
      sweep(tbl[i].dut, tbl[i].mode, tbl[i].rpct, cyc, sig);
      chk($sformatf("tbl%0d_sig", i), 32'(sig), 32'(tbl[i].exp_sig));
      if (tbl[i].exp_cyc > 0) chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
    end

    // backpressure hold at vector 3, then abort at vector 40
    mode_v[0] = 2;
    @(negedge clk);
    start_v[0] = 1'b1;
    ready_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (!(valid_v[0] && vec_v[0] == 7'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec3", 32'(vec_v[0]), 32'd3);
    ready_v[0] = 1'b0;
    s = sig_v[0];
    r = resp_v[0];
    chk("vec3_resp", 32'(r), 32'(cutf(2, 7'd3)));
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(valid_v[0]), 32'd1);
      chk("hold_vec", 32'(vec_v[0]), 32'd3);
      chk("hold_resp", 32'(resp_v[0]), 32'(r));
      chk("hold_x", 32'(x_v[0]), 32'd3);
      chk("hold_sig", 32'(sig_v[0]), 32'(s));
    end
    ready_v[0] = 1'b1;
    @(negedge clk);
    chk("post_hs_sig", 32'(sig_v[0]), 32'(misr(s, r)));
    chk("post_hs_valid", 32'(valid_v[0]), 32'd0);
    n = 0;
    while (!(valid_v[0] && vec_v[0] == 7'd40) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec40", 32'(vec_v[0]), 32'd40);
    abort_v[0] = 1'b1;
    s = sig_v[0];
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_valid", 32'(valid_v[0]), 32'd0);
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_sig", 32'(sig_v[0]), 32'(s));
    repeat (2) @(negedge clk);
    chk("abort_sig_frozen", 32'(sig_v[0]), 32'(s));
    chk("abort_stays_idle", 32'(busy_v[0]), 32'd0);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("abort_wins", 32'(busy_v[0]), 32'd0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("restart_busy", 32'(busy_v[0]), 32'd1);
    chk("restart_x", 32'(x_v[0]), 32'd0);
    chk("restart_sig", 32'(sig_v[0]), 32'hFFFF);
    @(negedge clk);
    chk("restart_valid", 32'(valid_v[0]), 32'd1);
    chk("restart_vec", 32'(vec_v[0]), 32'd0);
    chk("restart_resp", 32'(resp_v[0]), 32'(cutf(2, 7'd0)));
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;

    // asynchronous reset in the middle of a SETTLE window
    mode_v[1] = 1;
    start_v[1] = 1'b1;
    ready_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    n = 0;
    while (!(valid_v[1] && vec_v[1] == 7'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec5", 32'(vec_v[1]), 32'd5);
    @(negedge clk);
    chk("settle_x", 32'(x_v[1]), 32'd6);
    chk("settle_busy", 32'(busy_v[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_v[1]), 32'd0);
    chk("arst_done", 32'(done_v[1]), 32'd0);
    chk("arst_x", 32'(x_v[1]), 32'd0);
    chk("arst_valid", 32'(valid_v[1]), 32'd0);
    chk("arst_vec", 32'(vec_v[1]), 32'd0);
    chk("arst_resp", 32'(resp_v[1]), 32'd0);
    chk("arst_sig", 32'(sig_v[1]), 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy_v[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
